// File: rtl/cbus_pkg.sv
// -----------------------------------------------------------------------------
// cbus_pkg
// Shared CBus types and widths for the CPU-side bus fabric.
//   cbus_req_t  : one master's request bundle (valid, addr, size, wdata,
//                 wstrobe, burst, len)
//   cbus_resp_t : the slave's response bundle (ready, last, rdata)
//   arb_state_t : arbiter FSM states
//   wrap_inc()  : modulo-n increment used for the round-robin pointer
// -----------------------------------------------------------------------------
package cbus_pkg;

    localparam int CBUS_ADDR_W  = 64;
    localparam int CBUS_DATA_W  = 64;
    localparam int CBUS_SIZE_W  = 3;
    localparam int CBUS_STRB_W  = CBUS_DATA_W / 8;
    localparam int CBUS_BURST_W = 2;
    localparam int CBUS_LEN_W   = 8;

    typedef struct packed {
        logic                    valid;
        logic [CBUS_ADDR_W-1:0]  addr;
        logic [CBUS_SIZE_W-1:0]  size;
        logic [CBUS_DATA_W-1:0]  wdata;
        logic [CBUS_STRB_W-1:0]  wstrobe;
        logic [CBUS_BURST_W-1:0] burst;
        logic [CBUS_LEN_W-1:0]   len;
    } cbus_req_t;

    typedef struct packed {
        logic                   ready;
        logic                   last;
        logic [CBUS_DATA_W-1:0] rdata;
    } cbus_resp_t;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    // Next index after idx, wrapping to 0 at n.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/cbus_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Combinational round-robin selector. Scans req starting at index rr and
// moving upward with wrap (rr, rr+1 .. N-1, 0 .. rr-1); the first asserted
// request wins.
// Ports:
//   req     in  N       request vector
//   rr      in  IDX_W   index with highest priority this cycle
//   gnt_idx out IDX_W   winning index (0 when nothing is requested)
//   any     out 1       at least one request asserted
// -----------------------------------------------------------------------------
module rr_picker #(
    parameter  int N     = 2,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] rr,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             any
);

    int off;
    int best;

    // Each requester is ranked by its distance from rr going upward with
    // wrap; the smallest distance wins.
    always_comb begin
        // NOTE: every output of a combinational block gets a default before
        // any conditional assignment, otherwise a latch is inferred.
        gnt_idx = '0;
        any     = 1'b0;
        best    = N;
        off     = 0;
        for (int j = 0; j < N; j++) begin
            off = (j >= int'(rr)) ? (j - int'(rr)) : (j + N - int'(rr));
            if (req[j] && off < best) begin
                best    = off;
                gnt_idx = IDX_W'(j);
                any     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cbus_arbiter.sv
// -----------------------------------------------------------------------------
// cbus_arbiter
// N-master to 1-slave CBus arbiter (master 0 = ifetch, 1 = dcache).
// Round-robin grant, held for a whole burst. Request fields are forwarded
// combinationally from the owner; responses go back to the owner only.
// Optional build macro: CBUS_ARB_STATS_EN adds per-master statistics.
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   m_valid/addr/size/wdata/
//   m_wstrobe/burst/len        per-master request (wstrobe all-zero = read)
//   m_rdata                    read data broadcast to every master
//   m_ready, m_last            beat accepted / final beat, owner only
//   valid/addr/size/wdata/
//   wstrobe/burst/len          request to the crossbar (0 while idle)
//   rdata, ready, last         response from the crossbar
//   stat_grants   (stats)      completed transactions per master, wrapping
//   stat_wait_max (stats)      longest request-to-grant wait per master,
//                              saturating at 16'hFFFF
// -----------------------------------------------------------------------------
module cbus_arbiter
    import cbus_pkg::*;
#(
    parameter int N_MASTERS = 2
) (
    input  logic                                     clk,
    input  logic                                     reset,

    input  logic [N_MASTERS-1:0]                     m_valid,
    input  logic [N_MASTERS-1:0][CBUS_ADDR_W-1:0]    m_addr,
    input  logic [N_MASTERS-1:0][CBUS_SIZE_W-1:0]    m_size,
    input  logic [N_MASTERS-1:0][CBUS_DATA_W-1:0]    m_wdata,
    input  logic [N_MASTERS-1:0][CBUS_STRB_W-1:0]    m_wstrobe,
    input  logic [N_MASTERS-1:0][CBUS_BURST_W-1:0]   m_burst,
    input  logic [N_MASTERS-1:0][CBUS_LEN_W-1:0]     m_len,
    output logic [N_MASTERS-1:0][CBUS_DATA_W-1:0]    m_rdata,
    output logic [N_MASTERS-1:0]                     m_ready,
    output logic [N_MASTERS-1:0]                     m_last,

    output logic                                     valid,
    output logic [CBUS_ADDR_W-1:0]                   addr,
    output logic [CBUS_SIZE_W-1:0]                   size,
    output logic [CBUS_DATA_W-1:0]                   wdata,
    output logic [CBUS_STRB_W-1:0]                   wstrobe,
    output logic [CBUS_BURST_W-1:0]                  burst,
    output logic [CBUS_LEN_W-1:0]                    len,
    input  logic [CBUS_DATA_W-1:0]                   rdata,
    input  logic                                     ready,
    input  logic                                     last
`ifdef CBUS_ARB_STATS_EN
    ,
    output logic [N_MASTERS-1:0][31:0]               stat_grants,
    output logic [N_MASTERS-1:0][15:0]               stat_wait_max
`endif
);

    localparam int IDX_W = $clog2(N_MASTERS);

    arb_state_t       state;
    logic [IDX_W-1:0] g;         // current owner
    logic [IDX_W-1:0] rr;        // highest-priority master at next arbitration
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic             busy;
    logic             txn_end;
    logic             txn_abort;
    cbus_req_t        owner_req;
    cbus_req_t        down_req;
    cbus_resp_t       resp;

    rr_picker #(.N(N_MASTERS)) u_picker (
        .req     (m_valid),
        .rr      (rr),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    assign busy      = (state == ARB_BUSY);
    assign resp      = '{ready: ready, last: last, rdata: rdata};
    assign txn_end   = busy && resp.ready && resp.last;
    // Owner withdrew its request before the final beat.
    assign txn_abort = busy && !m_valid[g];

    // Request path: owner's fields while BUSY, all-zero otherwise. Because
    // state is reset asynchronously, valid drops the moment reset asserts.
    always_comb begin
        owner_req = '{valid:   m_valid[g],
                      addr:    m_addr[g],
                      size:    m_size[g],
                      wdata:   m_wdata[g],
                      wstrobe: m_wstrobe[g],
                      burst:   m_burst[g],
                      len:     m_len[g]};
        down_req  = busy ? owner_req : '0;
    end

    assign valid   = down_req.valid;
    assign addr    = down_req.addr;
    assign size    = down_req.size;
    assign wdata   = down_req.wdata;
    assign wstrobe = down_req.wstrobe;
    assign burst   = down_req.burst;
    assign len     = down_req.len;

    // Response path: handshake only to the owner, data broadcast.
    always_comb begin
        m_ready = '0;
        m_last  = '0;
        if (busy) begin
            m_ready[g] = resp.ready;
            m_last[g]  = resp.last;
        end
    end

    assign m_rdata = {N_MASTERS{resp.rdata}};

    // Grant FSM. IDLE always lasts at least one cycle, which is what yields
    // the mandatory bubble between back-to-back transactions.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: state registers use non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!reset) begin
            state <= ARB_IDLE;
            g     <= '0;
            rr    <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick_any) begin
                        g     <= pick_idx;
                        state <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    if (txn_end) begin
                        state <= ARB_IDLE;
                        rr    <= IDX_W'(wrap_inc(int'(g), N_MASTERS));
                    end else if (txn_abort) begin
                        // rr is left alone so an aborting master keeps its turn.
                        state <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

`ifdef CBUS_ARB_STATS_EN
    // wait_cnt counts cycles a master has held m_valid without owning the
    // bus; it is folded into stat_wait_max in the arbitration cycle that
    // grants that master.
    logic [N_MASTERS-1:0][15:0] wait_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_grants   <= '0;
            stat_wait_max <= '0;
            wait_cnt      <= '0;
        end else begin
            for (int i = 0; i < N_MASTERS; i++) begin
                if (txn_end && g == IDX_W'(i)) begin
                    stat_grants[i] <= stat_grants[i] + 32'd1;
                end
                if (!busy && pick_any && pick_idx == IDX_W'(i)) begin
                    if (wait_cnt[i] > stat_wait_max[i]) begin
                        stat_wait_max[i] <= wait_cnt[i];
                    end
                    wait_cnt[i] <= '0;
                end else if (m_valid[i] && !(busy && g == IDX_W'(i))) begin
                    if (wait_cnt[i] != 16'hFFFF) begin
                        wait_cnt[i] <= wait_cnt[i] + 16'd1;
                    end
                end else begin
                    wait_cnt[i] <= '0;
                end
            end
        end
    end
`endif

endmodule
